// File: rtl/tcp_tx_arbiter.sv
// Round-robin arbiter feeding three byte streams into a single SiTCP TX port.
// Each grant carries up to BURST_MAX bytes. Every grant is followed by a one-cycle GAP.
module tcp_tx_arbiter #(
    parameter int BURST_MAX = 1024
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        TCP_OPEN,
    input  logic        TCP_TX_FULL,
    output logic        TCP_TX_WR,
    output logic [7:0]  TCP_TX_DATA,
    input  logic [2:0]  REQ,
    input  logic [2:0]  VALID,
    input  logic [7:0]  DATA0,
    input  logic [7:0]  DATA1,
    input  logic [7:0]  DATA2,
    output logic [2:0]  READY,
    output logic [2:0]  GRANT,
    output logic [31:0] TX_BYTES
);

    typedef enum logic [1:0] {IDLE, XFER, GAP} state_t;

    localparam logic [16:0] BMAX = 17'(BURST_MAX);

    state_t      state_q, state_d;
    logic [1:0]  ptr_q, ptr_d;
    logic [1:0]  gidx_q, gidx_d;
    logic [2:0]  gnt_q, gnt_d;
    logic [15:0] cnt_q, cnt_d;
    logic        open_q, full_q;
    logic        wr_q;
    logic [7:0]  data_q;
    logic [31:0] bytes_q;

    logic [1:0]  cand1, cand2, pick_idx;
    logic        pick_vld;
    logic [7:0]  data_g;
    logic        req_g, ready_g, take, last;
    logic [16:0] cnt_inc;

    function automatic logic [1:0] nxt(input logic [1:0] i);
        return (i == 2'd2) ? 2'd0 : i + 2'd1;
    endfunction

    function automatic logic [2:0] onehot(input logic [1:0] i);
        return 3'b001 << i;
    endfunction

    // Upward search from ptr, wrapping modulo 3
    always_comb begin
        cand1    = nxt(ptr_q);
        cand2    = nxt(cand1);
        pick_vld = 1'b1;
        pick_idx = ptr_q;
        if (REQ[ptr_q])      pick_idx = ptr_q;
        else if (REQ[cand1]) pick_idx = cand1;
        else if (REQ[cand2]) pick_idx = cand2;
        else                 pick_vld = 1'b0;
    end

    always_comb begin
        data_g = DATA0;
        case (gidx_q)
            2'd1:    data_g = DATA1;
            2'd2:    data_g = DATA2;
            default: data_g = DATA0;
        endcase
    end

    assign req_g   = REQ[gidx_q];
    assign ready_g = (state_q == XFER) & req_g & open_q & ~full_q;
    assign take    = ready_g & VALID[gidx_q];
    assign cnt_inc = {1'b0, cnt_q} + 17'd1;
    assign last    = take & (cnt_inc == BMAX);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gidx_d  = gidx_q;
        gnt_d   = gnt_q;
        cnt_d   = cnt_q;
        if (!open_q) begin
            state_d = IDLE;
            ptr_d   = 2'd0;
            gnt_d   = 3'b000;
            cnt_d   = 16'd0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (pick_vld) begin
                        gidx_d  = pick_idx;
                        gnt_d   = onehot(pick_idx);
                        cnt_d   = 16'd0;
                        state_d = XFER;
                    end
                end
                XFER: begin
                    if (take) cnt_d = cnt_inc[15:0];
                    if (!req_g || last) begin
                        state_d = GAP;
                        ptr_d   = nxt(gidx_q);
                        gnt_d   = 3'b000;
                    end
                end
                GAP:     state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            ptr_q   <= 2'd0;
            gidx_q  <= 2'd0;
            gnt_q   <= 3'b000;
            cnt_q   <= 16'd0;
            open_q  <= 1'b0;
            full_q  <= 1'b0;
            wr_q    <= 1'b0;
            data_q  <= 8'h00;
            bytes_q <= 32'd0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gidx_q  <= gidx_d;
            gnt_q   <= gnt_d;
            cnt_q   <= cnt_d;
            open_q  <= TCP_OPEN;
            full_q  <= TCP_TX_FULL;
            wr_q    <= take;
            if (take) data_q <= data_g;
            // Counter restarts on the same edge open_r rises
            if (TCP_OPEN && !open_q) bytes_q <= 32'd0;
            else if (take)           bytes_q <= bytes_q + 32'd1;
        end
    end

    assign READY       = {3{ready_g}} & gnt_q;
    assign GRANT       = gnt_q & REQ & {3{open_q}};
    assign TCP_TX_WR   = wr_q;
    assign TCP_TX_DATA = data_q;
    assign TX_BYTES    = bytes_q;

endmodule

// File: tb/tb_tcp_tx_arbiter.sv
// Directed bench for tcp_tx_arbiter with BURST_MAX=4.
// Per-cycle vectors: round-robin table, then hand sequences for stall/drop/close/reset.
module tb_tcp_tx_arbiter;

    logic        CLK;
    logic        RST;
    logic        TCP_OPEN;
    logic        TCP_TX_FULL;
    logic        TCP_TX_WR;
    logic [7:0]  TCP_TX_DATA;
    logic [2:0]  REQ;
    logic [2:0]  VALID;
    logic [7:0]  DATA0, DATA1, DATA2;
    logic [2:0]  READY;
    logic [2:0]  GRANT;
    logic [31:0] TX_BYTES;

    int n_chk  = 0;
    int n_fail = 0;

    tcp_tx_arbiter #(.BURST_MAX(4)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .TCP_OPEN   (TCP_OPEN),
        .TCP_TX_FULL(TCP_TX_FULL),
        .TCP_TX_WR  (TCP_TX_WR),
        .TCP_TX_DATA(TCP_TX_DATA),
        .REQ        (REQ),
        .VALID      (VALID),
        .DATA0      (DATA0),
        .DATA1      (DATA1),
        .DATA2      (DATA2),
        .READY      (READY),
        .GRANT      (GRANT),
        .TX_BYTES   (TX_BYTES)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic       rst;
        logic       open;
        logic       full;
        logic [2:0] req;
        logic [2:0] valid;
        logic [2:0] grant;
        logic [2:0] ready;
        logic       wr;
        logic [7:0] data;
    } vec_t;

    function automatic vec_t mk(input logic rst, input logic open,
                                input logic full, input logic [2:0] req,
                                input logic [2:0] valid, input logic [2:0] grant,
                                input logic [2:0] ready, input logic wr,
                                input logic [7:0] data);
        vec_t v;
        v.rst   = rst;
        v.open  = open;
        v.full  = full;
        v.req   = req;
        v.valid = valid;
        v.grant = grant;
        v.ready = ready;
        v.wr    = wr;
        v.data  = data;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Drive one cycle's inputs after the edge, check outputs at the falling edge
    task automatic cyc(input vec_t v, input string nm);
        @(posedge CLK);
        #1;
        RST         = v.rst;
        TCP_OPEN    = v.open;
        TCP_TX_FULL = v.full;
        REQ         = v.req;
        VALID       = v.valid;
        @(negedge CLK);
        chk({nm, ".grant"}, {29'd0, GRANT}, {29'd0, v.grant});
        chk({nm, ".ready"}, {29'd0, READY}, {29'd0, v.ready});
        chk({nm, ".wr"},    {31'd0, TCP_TX_WR}, {31'd0, v.wr});
        chk({nm, ".data"},  {24'd0, TCP_TX_DATA}, {24'd0, v.data});
    endtask

    vec_t tbl[22];

    initial begin
        tbl[0]  = mk(0, 1, 0, 3'd7, 3'd7, 3'd0, 3'd0, 0, 8'h00);
        tbl[1]  = mk(0, 1, 0, 3'd7, 3'd7, 3'd0, 3'd0, 0, 8'h00);
        tbl[2]  = mk(0, 1, 0, 3'd7, 3'd7, 3'd1, 3'd1, 0, 8'h00);
        tbl[3]  = mk(0, 1, 0, 3'd7, 3'd7, 3'd1, 3'd1, 1, 8'hA0);
        tbl[4]  = mk(0, 1, 0, 3'd7, 3'd7, 3'd1, 3'd1, 1, 8'hA0);
        tbl[5]  = mk(0, 1, 0, 3'd7, 3'd7, 3'd1, 3'd1, 1, 8'hA0);
        tbl[6]  = mk(0, 1, 0, 3'd7, 3'd7, 3'd0, 3'd0, 1, 8'hA0);
        tbl[7]  = mk(0, 1, 0, 3'd7, 3'd7, 3'd0, 3'd0, 0, 8'hA0);
        tbl[8]  = mk(0, 1, 0, 3'd7, 3'd7, 3'd2, 3'd2, 0, 8'hA0);
        tbl[9]  = mk(0, 1, 0, 3'd7, 3'd7, 3'd2, 3'd2, 1, 8'hA1);
        tbl[10] = mk(0, 1, 0, 3'd7, 3'd7, 3'd2, 3'd2, 1, 8'hA1);
        tbl[11] = mk(0, 1, 0, 3'd7, 3'd7, 3'd2, 3'd2, 1, 8'hA1);
        tbl[12] = mk(0, 1, 0, 3'd7, 3'd7, 3'd0, 3'd0, 1, 8'hA1);
        tbl[13] = mk(0, 1, 0, 3'd7, 3'd7, 3'd0, 3'd0, 0, 8'hA1);
        tbl[14] = mk(0, 1, 0, 3'd7, 3'd7, 3'd4, 3'd4, 0, 8'hA1);
        tbl[15] = mk(0, 1, 0, 3'd7, 3'd7, 3'd4, 3'd4, 1, 8'hA2);
        tbl[16] = mk(0, 1, 0, 3'd7, 3'd7, 3'd4, 3'd4, 1, 8'hA2);
        tbl[17] = mk(0, 1, 0, 3'd7, 3'd7, 3'd4, 3'd4, 1, 8'hA2);
        tbl[18] = mk(0, 1, 0, 3'd7, 3'd7, 3'd0, 3'd0, 1, 8'hA2);
        tbl[19] = mk(0, 1, 0, 3'd7, 3'd7, 3'd0, 3'd0, 0, 8'hA2);
        tbl[20] = mk(0, 1, 0, 3'd7, 3'd7, 3'd1, 3'd1, 0, 8'hA2);
        tbl[21] = mk(0, 1, 0, 3'd7, 3'd7, 3'd1, 3'd1, 1, 8'hA0);

        RST         = 1'b1;
        TCP_OPEN    = 1'b0;
        TCP_TX_FULL = 1'b0;
        REQ         = 3'd0;
        VALID       = 3'd0;
        DATA0       = 8'hA0;
        DATA1       = 8'hA1;
        DATA2       = 8'hA2;

        // Reset state
        cyc(mk(1, 0, 0, 3'd0, 3'd0, 3'd0, 3'd0, 0, 8'h00), "rst0");
        cyc(mk(1, 0, 0, 3'd0, 3'd0, 3'd0, 3'd0, 0, 8'h00), "rst1");
        chk("rst.bytes", TX_BYTES, 32'd0);

        // Round robin with all requesters busy
        for (int i = 0; i < 22; i++) cyc(tbl[i], $sformatf("rr%0d", i));
        chk("rr.bytes", TX_BYTES, 32'd13);

        // Reset pulse mid-burst
        cyc(mk(1, 1, 0, 3'd7, 3'd7, 3'd1, 3'd1, 1, 8'hA0), "mr0");
        cyc(mk(1, 1, 0, 3'd7, 3'd7, 3'd0, 3'd0, 0, 8'h00), "mr1");
        chk("mr.bytes", TX_BYTES, 32'd0);

        // Lone requester 1 with gapped VALID
        cyc(mk(0, 1, 0, 3'd2, 3'd0, 3'd0, 3'd0, 0, 8'h00), "v0");
        cyc(mk(0, 1, 0, 3'd2, 3'd0, 3'd0, 3'd0, 0, 8'h00), "v1");
        cyc(mk(0, 1, 0, 3'd2, 3'd2, 3'd2, 3'd2, 0, 8'h00), "v2");
        cyc(mk(0, 1, 0, 3'd2, 3'd0, 3'd2, 3'd2, 1, 8'hA1), "v3");
        cyc(mk(0, 1, 0, 3'd2, 3'd2, 3'd2, 3'd2, 0, 8'hA1), "v4");
        cyc(mk(0, 1, 0, 3'd2, 3'd0, 3'd2, 3'd2, 1, 8'hA1), "v5");
        cyc(mk(0, 1, 0, 3'd2, 3'd0, 3'd2, 3'd2, 0, 8'hA1), "v6");
        chk("v.bytes", TX_BYTES, 32'd2);

        // REQ[1] dropped mid-burst, requester 2 takes over after GAP/IDLE
        cyc(mk(0, 1, 0, 3'd4, 3'd7, 3'd0, 3'd0, 0, 8'hA1), "d0");
        cyc(mk(0, 1, 0, 3'd4, 3'd7, 3'd0, 3'd0, 0, 8'hA1), "d1");
        cyc(mk(0, 1, 0, 3'd4, 3'd7, 3'd0, 3'd0, 0, 8'hA1), "d2");
        cyc(mk(0, 1, 0, 3'd4, 3'd7, 3'd4, 3'd4, 0, 8'hA1), "d3");
        cyc(mk(0, 1, 0, 3'd4, 3'd7, 3'd4, 3'd4, 1, 8'hA2), "d4");
        chk("d.bytes", TX_BYTES, 32'd3);

        // FULL high for 5 cycles in the middle of the burst
        cyc(mk(0, 1, 1, 3'd4, 3'd7, 3'd4, 3'd4, 1, 8'hA2), "f0");
        cyc(mk(0, 1, 1, 3'd4, 3'd7, 3'd4, 3'd0, 1, 8'hA2), "f1");
        cyc(mk(0, 1, 1, 3'd4, 3'd7, 3'd4, 3'd0, 0, 8'hA2), "f2");
        cyc(mk(0, 1, 1, 3'd4, 3'd7, 3'd4, 3'd0, 0, 8'hA2), "f3");
        cyc(mk(0, 1, 1, 3'd4, 3'd7, 3'd4, 3'd0, 0, 8'hA2), "f4");
        cyc(mk(0, 1, 0, 3'd4, 3'd7, 3'd4, 3'd0, 0, 8'hA2), "f5");
        cyc(mk(0, 1, 0, 3'd4, 3'd7, 3'd4, 3'd4, 0, 8'hA2), "f6");
        cyc(mk(0, 1, 0, 3'd4, 3'd7, 3'd0, 3'd0, 1, 8'hA2), "f7");
        chk("f.bytes", TX_BYTES, 32'd6);

        // Connection closes mid-burst, then reopens
        cyc(mk(0, 1, 0, 3'd7, 3'd7, 3'd0, 3'd0, 0, 8'hA2), "c0");
        cyc(mk(0, 1, 0, 3'd7, 3'd7, 3'd1, 3'd1, 0, 8'hA2), "c1");
        cyc(mk(0, 0, 0, 3'd7, 3'd7, 3'd1, 3'd1, 1, 8'hA0), "c2");
        cyc(mk(0, 0, 0, 3'd7, 3'd7, 3'd0, 3'd0, 1, 8'hA0), "c3");
        cyc(mk(0, 0, 0, 3'd7, 3'd7, 3'd0, 3'd0, 0, 8'hA0), "c4");
        chk("c4.bytes", TX_BYTES, 32'd8);
        cyc(mk(0, 1, 0, 3'd6, 3'd6, 3'd0, 3'd0, 0, 8'hA0), "c5");
        chk("c5.bytes", TX_BYTES, 32'd8);
        cyc(mk(0, 1, 0, 3'd6, 3'd6, 3'd0, 3'd0, 0, 8'hA0), "c6");
        chk("c6.bytes", TX_BYTES, 32'd0);
        cyc(mk(0, 1, 0, 3'd6, 3'd6, 3'd2, 3'd2, 0, 8'hA0), "c7");
        cyc(mk(0, 1, 0, 3'd6, 3'd6, 3'd2, 3'd2, 1, 8'hA1), "c8");
        chk("c8.bytes", TX_BYTES, 32'd1);

        // Second reset pulse: nothing emitted afterwards
        cyc(mk(1, 1, 0, 3'd6, 3'd6, 3'd2, 3'd2, 1, 8'hA1), "r0");
        cyc(mk(0, 1, 0, 3'd6, 3'd6, 3'd0, 3'd0, 0, 8'h00), "r1");
        chk("r1.bytes", TX_BYTES, 32'd0);
        cyc(mk(0, 1, 0, 3'd6, 3'd6, 3'd0, 3'd0, 0, 8'h00), "r2");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
